// File: rtl/tff_pkg.sv
// Shared mode encoding for the T flip-flop bank.
package tff_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD   = 2'b00;
    localparam mode_t MODE_TOGGLE = 2'b01;
    localparam mode_t MODE_UP     = 2'b10;
    localparam mode_t MODE_DOWN   = 2'b11;

endpackage

// File: rtl/tff_bank_if.sv
// Control/status bundle of tff_bank; the bank itself is the slave.
interface tff_bank_if
    import tff_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] t;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, t, load, d,
        input  q, tc, wrap
    );

    modport slave (
        input  en, mode, t, load, d,
        output q, tc, wrap
    );
endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low reset and synchronous load.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic tog,
    input  logic ld,
    input  logic d,
    input  logic rst_val,
    output logic q
);
    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (tog) begin
            q_d = ~q_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/tff_bank.sv
// WIDTH-bit bank of T cells: independent toggle bits or up/down counter via carry/borrow chain.
// Define TFF_BANK_SAT_EN to make the count modes saturate at terminal count instead of wrapping.
module tff_bank
    import tff_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic       clk,
    input logic       rst_n,
    tff_bank_if.slave bus
);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] chain;
    logic [WIDTH-1:0] tog;
    logic             is_toggle, is_up, is_down;
    logic             count_step, tc, sat_hold;
    logic             wrap_d, wrap_q;

    always_comb begin
        is_toggle = 1'b0;
        is_up     = 1'b0;
        is_down   = 1'b0;
        case (bus.mode)
            MODE_TOGGLE: is_toggle = 1'b1;
            MODE_UP:     is_up     = 1'b1;
            MODE_DOWN:   is_down   = 1'b1;
            default:     ;
        endcase
    end

    // Running accumulators keep the chain free of vector self-dependency.
    always_comb begin
        logic c_acc;
        logic b_acc;
        c_acc = 1'b1;
        b_acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i]  = c_acc;
            borrow[i] = b_acc;
            c_acc     = c_acc & q[i];
            b_acc     = b_acc & ~q[i];
        end
    end

    always_comb begin
        tc         = (is_up & (&q)) | (is_down & ~(|q));
        count_step = bus.en & (is_up | is_down);
`ifdef TFF_BANK_SAT_EN
        sat_hold   = tc;
        wrap_d     = 1'b0;
`else
        sat_hold   = 1'b0;
        wrap_d     = ~bus.load & count_step & tc;
`endif
        chain      = is_up ? carry : (is_down ? borrow : '0);
        tog        = {WIDTH{bus.en}} &
                     (({WIDTH{is_toggle}} & bus.t) | ({WIDTH{count_step & ~sat_hold}} & chain));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .tog     (tog[i]),
            .ld      (bus.load),
            .d       (bus.d[i]),
            .rst_val (RST_VAL[i]),
            .q       (q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_q;
endmodule
